// File: rtl/line_fill_receiver_pkg.sv
// Shared definitions for the line fill receiver: bus opcodes, beat geometry
// and the controller state encoding.
package line_fill_receiver_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_PWB  = 2'b11
  } bus_op_t;

  localparam int unsigned LFR_NUM_BEATS = 4;
  localparam int unsigned LFR_PORTION_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DATA,
    ST_RECEIVE,
    ST_DONE
  } lfr_state_t;

endpackage

// File: rtl/line_fill_receiver_if.sv
// Cache-side, memory-queue and bus signals of the line fill receiver.
// The master modport is the receiver itself; slave is its environment.
interface line_fill_receiver_if
  import line_fill_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_BEATS  = LFR_NUM_BEATS
);
  logic                          miss_valid;
  logic [ADDR_WIDTH-1:0]         miss_addr;
  logic                          miss_ready;

  logic                          req_valid;
  logic [1:0]                    req_op;
  logic [ADDR_WIDTH-1:0]         req_addr;
  logic                          req_ready;

  logic                          bus_hold;
  logic                          bus_direction;
  logic [LFR_PORTION_W-1:0]      bus_portion;
  logic [DATA_WIDTH-1:0]         bus_data;

  logic                          fill_valid;
  logic [ADDR_WIDTH-1:0]         fill_addr;
  logic [NUM_BEATS*DATA_WIDTH-1:0] fill_data;
  logic                          fill_error;

  modport master (
    input  miss_valid, miss_addr,
    output miss_ready,
    output req_valid, req_op, req_addr,
    input  req_ready,
    input  bus_hold, bus_direction, bus_portion, bus_data,
    output fill_valid, fill_addr, fill_data, fill_error
  );

  modport slave (
    output miss_valid, miss_addr,
    input  miss_ready,
    input  req_valid, req_op, req_addr,
    output req_ready,
    output bus_hold, bus_direction, bus_portion, bus_data,
    input  fill_valid, fill_addr, fill_data, fill_error
  );

endinterface

// File: rtl/line_assembly_buffer.sv
// Beat slots and arrival mask for one cache line. o_full and o_line already
// include the beat being written this cycle so the line can be captured at once.
module line_assembly_buffer
  import line_fill_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BEATS  = LFR_NUM_BEATS
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_clear,
  input  logic                            i_write_en,
  input  logic [LFR_PORTION_W-1:0]        i_portion,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_full,
  output logic [NUM_BEATS*DATA_WIDTH-1:0] o_line
);

  logic [DATA_WIDTH-1:0] r_slot [NUM_BEATS];
  logic [NUM_BEATS-1:0]  r_mask;
  logic [NUM_BEATS-1:0]  w_mask_next;

  always_comb begin
    w_mask_next = r_mask;
    o_line      = '0;
    for (int unsigned i = 0; i < NUM_BEATS; i++) begin
      o_line[i*DATA_WIDTH +: DATA_WIDTH] = r_slot[i];
    end
    if (i_write_en) begin
      w_mask_next[i_portion] = 1'b1;
      o_line[32'(i_portion)*DATA_WIDTH +: DATA_WIDTH] = i_data;
    end
    o_full = &w_mask_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_mask <= '0;
      for (int unsigned i = 0; i < NUM_BEATS; i++) begin
        r_slot[i] <= '0;
      end
    end else if (i_write_en) begin
      r_slot[i_portion] <= i_data;
      r_mask            <= w_mask_next;
    end
  end

endmodule

// File: rtl/line_fill_receiver.sv
// Cache-side bus initiator: issues an RD for a missed line, assembles the
// returning burst in any beat order and returns it as a one-cycle fill pulse.
module line_fill_receiver
  import line_fill_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_BEATS      = LFR_NUM_BEATS,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 rst,
  line_fill_receiver_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned LINE_W = NUM_BEATS * DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lfr_state_t              r_state;
  logic                    r_miss_ready;
  logic                    r_req_valid;
  bus_op_t                 r_req_op;
  logic [ADDR_WIDTH-1:0]   r_req_addr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_fill_valid;
  logic                    r_fill_error;
  logic [ADDR_WIDTH-1:0]   r_fill_addr;
  logic [LINE_W-1:0]       r_fill_data;

  logic                    w_beat;
  logic                    w_clear;
  logic                    w_write;
  logic                    w_full;
  logic [LINE_W-1:0]       w_line;

  assign w_beat  = bus.bus_hold && bus.bus_direction;
  assign w_clear = (r_state == ST_ISSUE) && bus.req_ready;
  assign w_write = w_beat && ((r_state == ST_WAIT_DATA) || (r_state == ST_RECEIVE));

  line_assembly_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_BEATS  (NUM_BEATS)
  ) u_line_assembly_buffer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_clear),
    .i_write_en (w_write),
    .i_portion  (bus.bus_portion),
    .i_data     (bus.bus_data),
    .o_full     (w_full),
    .o_line     (w_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_miss_ready <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_op     <= OP_NONE;
      r_req_addr   <= '0;
      r_cnt        <= '0;
      r_fill_valid <= 1'b0;
      r_fill_error <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_data  <= '0;
    end else begin
      r_fill_valid <= 1'b0;
      r_fill_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // miss_ready is registered, so a miss only counts once it is visible
          if (r_miss_ready && bus.miss_valid) begin
            r_req_addr   <= bus.miss_addr;
            r_req_valid  <= 1'b1;
            r_req_op     <= OP_RD;
            r_miss_ready <= 1'b0;
            r_state      <= ST_ISSUE;
          end else begin
            r_miss_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (bus.req_ready) begin
            r_req_valid <= 1'b0;
            r_req_op    <= OP_NONE;
            r_cnt       <= CNT_LOAD;
            r_state     <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (w_beat) begin
            r_state <= ST_RECEIVE;
          end else if (r_cnt == CNT_ONE) begin
            r_fill_error <= 1'b1;
            r_miss_ready <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        ST_RECEIVE: begin
          if (w_beat && w_full) begin
            r_fill_valid <= 1'b1;
            r_fill_addr  <= r_req_addr;
            r_fill_data  <= w_line;
            r_state      <= ST_DONE;
          end else if (!bus.bus_hold) begin
            r_fill_error <= 1'b1;
            r_miss_ready <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        ST_DONE: begin
          r_miss_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.miss_ready = r_miss_ready;
  assign bus.req_valid  = r_req_valid;
  assign bus.req_op     = r_req_op;
  assign bus.req_addr   = r_req_addr;
  assign bus.fill_valid = r_fill_valid;
  assign bus.fill_error = r_fill_error;
  assign bus.fill_addr  = r_fill_addr;
  assign bus.fill_data  = r_fill_data;

endmodule

// File: tb/tb_line_fill_receiver.sv
// Randomized self-checking bench for line_fill_receiver; expected outcomes are
// derived from a per-transaction beat plan using the fill/timeout/abort rules.
module tb_line_fill_receiver;
  import line_fill_receiver_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned NB   = 4;
  localparam int unsigned TO   = 8;
  localparam int unsigned LW   = NB * DW;
  localparam int unsigned PMAX = 64;

  logic clk = 1'b0;
  logic rst;

  line_fill_receiver_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BEATS(NB)) bus_if ();

  line_fill_receiver #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .NUM_BEATS      (NB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat plan, indexed by cycle counted from the first cycle after req_ready.
  logic            plan_hold [PMAX];
  logic            plan_dir  [PMAX];
  logic [1:0]      plan_por  [PMAX];
  logic [DW-1:0]   plan_dat  [PMAX];
  int unsigned     plan_len;

  task automatic plan_clear();
    plan_len = 0;
  endtask

  task automatic plan_add(input logic h, input logic d, input logic [1:0] p, input logic [DW-1:0] v);
    if (plan_len < PMAX) begin
      plan_hold[plan_len] = h;
      plan_dir[plan_len]  = d;
      plan_por[plan_len]  = p;
      plan_dat[plan_len]  = v;
      plan_len++;
    end
  endtask

  task automatic plan_beat(input logic [1:0] p, input logic [DW-1:0] v);
    plan_add(1'b1, 1'b1, p, v);
  endtask

  task automatic drive_bus(input logic h, input logic d, input logic [1:0] p, input logic [DW-1:0] v);
    bus_if.bus_hold      = h;
    bus_if.bus_direction = d;
    bus_if.bus_portion   = p;
    bus_if.bus_data      = v;
  endtask

  // Outcome of a plan: fill or error, and the relative cycle of the pulse.
  task automatic predict(output bit is_fill, output int unsigned when, output logic [LW-1:0] line);
    int              first;
    logic [DW-1:0]   slot [NB];
    bit              seen [NB];
    int unsigned     nseen;
    logic            h, d;
    logic [1:0]      p;
    logic [DW-1:0]   v;
    is_fill = 1'b0;
    when    = TO - 1;
    line    = '0;
    first   = -1;
    for (int c = 0; c <= int'(TO) - 2 && c < int'(plan_len); c++) begin
      if (plan_hold[c] && plan_dir[c]) begin
        first = c;
        break;
      end
    end
    if (first < 0) return;
    for (int i = 0; i < int'(NB); i++) begin
      slot[i] = '0;
      seen[i] = 1'b0;
    end
    nseen = 0;
    for (int c = first; c <= int'(plan_len); c++) begin
      h = (c < int'(plan_len)) ? plan_hold[c] : 1'b0;
      d = (c < int'(plan_len)) ? plan_dir[c]  : 1'b0;
      p = (c < int'(plan_len)) ? plan_por[c]  : 2'd0;
      v = (c < int'(plan_len)) ? plan_dat[c]  : '0;
      if (h && d) begin
        slot[p] = v;
        if (!seen[p]) begin
          seen[p] = 1'b1;
          nseen++;
        end
        if (nseen == NB) begin
          is_fill = 1'b1;
          when    = c + 1;
          for (int i = 0; i < int'(NB); i++) line[i*DW +: DW] = slot[i];
          return;
        end
      end else if (!h) begin
        when = c + 1;
        return;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_miss_ready", bus_if.miss_ready, 0);
    check_eq("rst_req_valid",  bus_if.req_valid, 0);
    check_eq("rst_req_op",     bus_if.req_op, 0);
    check_eq("rst_req_addr",   bus_if.req_addr, 0);
    check_eq("rst_fill_valid", bus_if.fill_valid, 0);
    check_eq("rst_fill_error", bus_if.fill_error, 0);
    check_eq("rst_fill_addr",  bus_if.fill_addr, 0);
    check_eq("rst_fill_data",  bus_if.fill_data, 0);
  endtask

  task automatic run_fill(input logic [AW-1:0] addr, input int unsigned rdy_delay);
    bit            is_fill;
    int unsigned   when;
    logic [LW-1:0] exp_line;
    predict(is_fill, when, exp_line);
    check_eq("miss_ready_idle", bus_if.miss_ready, 1);
    bus_if.miss_valid = 1'b1;
    bus_if.miss_addr  = addr;
    step();
    bus_if.miss_valid = 1'b0;
    bus_if.miss_addr  = $urandom;
    for (int unsigned i = 0; i <= rdy_delay; i++) begin
      check_eq("req_valid_issue", bus_if.req_valid, 1);
      check_eq("req_op_issue",    bus_if.req_op, OP_RD);
      check_eq("req_addr_issue",  bus_if.req_addr, addr);
      check_eq("miss_ready_busy", bus_if.miss_ready, 0);
      bus_if.req_ready = (i == rdy_delay);
      drive_bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom), $urandom);
      step();
    end
    bus_if.req_ready = 1'b0;
    check_eq("req_valid_drop", bus_if.req_valid, 0);
    for (int unsigned c = 0; c <= when; c++) begin
      check_eq("fill_valid", bus_if.fill_valid, is_fill && (c == when));
      check_eq("fill_error", bus_if.fill_error, !is_fill && (c == when));
      if (is_fill && (c == when)) begin
        check_eq("fill_data", bus_if.fill_data, exp_line);
        check_eq("fill_addr", bus_if.fill_addr, addr);
      end
      if (c < plan_len) drive_bus(plan_hold[c], plan_dir[c], plan_por[c], plan_dat[c]);
      else              drive_bus(1'b0, 1'b0, 2'd0, '0);
      step();
    end
    drive_bus(1'b0, 1'b0, 2'd0, '0);
    check_eq("fill_valid_after", bus_if.fill_valid, 0);
    check_eq("fill_error_after", bus_if.fill_error, 0);
    check_eq("miss_ready_back",  bus_if.miss_ready, 1);
  endtask

  task automatic gen_random_plan();
    int unsigned lead, tmp, j, cut;
    int unsigned perm [NB];
    bit          trunc;
    logic        h;
    plan_clear();
    lead = $urandom_range(0, TO + 1);
    for (int unsigned i = 0; i < lead; i++) begin
      h = 1'($urandom_range(0, 1));
      plan_add(h, h ? 1'b0 : 1'($urandom_range(0, 1)), 2'($urandom), $urandom);
    end
    if ($urandom_range(0, 9) == 0) return;
    for (int unsigned i = 0; i < NB; i++) perm[i] = i;
    for (int unsigned i = NB - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    trunc = ($urandom_range(0, 4) == 0);
    cut   = $urandom_range(1, NB - 1);
    for (int unsigned i = 0; i < NB; i++) begin
      if (trunc && i == cut) begin
        plan_add(1'b0, 1'($urandom_range(0, 1)), 2'($urandom), $urandom);
        plan_beat(2'(perm[i]), $urandom);
        break;
      end
      plan_beat(2'(perm[i]), $urandom);
      if ($urandom_range(0, 3) == 0) plan_beat(2'(perm[$urandom_range(0, i)]), $urandom);
      if ($urandom_range(0, 3) == 0) plan_add(1'b1, 1'b0, 2'($urandom), $urandom);
    end
  endtask

  task automatic reset_mid_burst();
    check_eq("miss_ready_pre_rst", bus_if.miss_ready, 1);
    bus_if.miss_valid = 1'b1;
    bus_if.miss_addr  = 32'h2000;
    step();
    bus_if.miss_valid = 1'b0;
    bus_if.req_ready  = 1'b1;
    step();
    bus_if.req_ready = 1'b0;
    drive_bus(1'b1, 1'b1, 2'd3, 32'hE3);
    step();
    drive_bus(1'b1, 1'b1, 2'd2, 32'hE2);
    step();
    rst = 1'b1;
    drive_bus(1'b1, 1'b1, 2'd1, 32'hE1);
    step();
    rst = 1'b0;
    check_reset_outputs();
    drive_bus(1'b1, 1'b1, 2'd0, 32'hE0);
    step();
    check_eq("mid_rst_no_fill",  bus_if.fill_valid, 0);
    check_eq("mid_rst_no_error", bus_if.fill_error, 0);
    check_eq("mid_rst_ready",    bus_if.miss_ready, 1);
    drive_bus(1'b0, 1'b0, 2'd0, '0);
    step();
    check_eq("mid_rst_no_fill2",  bus_if.fill_valid, 0);
    check_eq("mid_rst_no_error2", bus_if.fill_error, 0);
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.miss_valid = 1'b0;
    bus_if.miss_addr  = '0;
    bus_if.req_ready  = 1'b0;
    drive_bus(1'b0, 1'b0, 2'd0, '0);
    step();
    step();
    check_reset_outputs();
    rst = 1'b0;
    step();
    check_eq("miss_ready_after_rst", bus_if.miss_ready, 1);

    // Stray beats while idle must not produce anything.
    for (int unsigned i = 0; i < NB; i++) begin
      drive_bus(1'b1, 1'b1, 2'(i), $urandom);
      step();
      check_eq("idle_no_fill",  bus_if.fill_valid, 0);
      check_eq("idle_no_error", bus_if.fill_error, 0);
      check_eq("idle_ready",    bus_if.miss_ready, 1);
    end
    drive_bus(1'b0, 1'b0, 2'd0, '0);
    step();

    // Nominal descending burst, minimum latency.
    plan_clear();
    plan_beat(2'd3, 32'hD3);
    plan_beat(2'd2, 32'hD2);
    plan_beat(2'd1, 32'hD1);
    plan_beat(2'd0, 32'hD0);
    run_fill(32'h1000, 0);

    // Queue backpressure.
    plan_clear();
    plan_beat(2'd0, 32'h10);
    plan_beat(2'd1, 32'h11);
    plan_beat(2'd2, 32'h12);
    plan_beat(2'd3, 32'h13);
    run_fill(32'h3040, 5);

    // Timeout with no beats at all.
    plan_clear();
    run_fill(32'h4000, 0);

    // First beat on the last waiting cycle still succeeds.
    plan_clear();
    for (int unsigned i = 0; i < TO - 2; i++) plan_add(1'b0, 1'b0, 2'd0, '0);
    for (int unsigned i = 0; i < NB; i++) plan_beat(2'(i), 32'hC0 + i);
    run_fill(32'h5000, 1);

    // One cycle later is a timeout.
    plan_clear();
    for (int unsigned i = 0; i < TO - 1; i++) plan_add(1'b0, 1'b0, 2'd0, '0);
    for (int unsigned i = 0; i < NB; i++) plan_beat(2'(i), 32'hC8 + i);
    run_fill(32'h5100, 0);

    // Truncated burst, then a normal fill.
    plan_clear();
    plan_beat(2'd1, 32'hF1);
    plan_beat(2'd3, 32'hF3);
    plan_add(1'b0, 1'b0, 2'd0, '0);
    plan_beat(2'd0, 32'hF0);
    plan_beat(2'd2, 32'hF2);
    run_fill(32'h6000, 0);
    plan_clear();
    plan_beat(2'd2, 32'h22);
    plan_beat(2'd0, 32'h20);
    plan_beat(2'd3, 32'h23);
    plan_beat(2'd1, 32'h21);
    run_fill(32'h6100, 2);

    // Duplicate portion: the later value wins.
    plan_clear();
    plan_beat(2'd3, 32'h33);
    plan_beat(2'd2, 32'hAA);
    plan_beat(2'd2, 32'hBB);
    plan_beat(2'd1, 32'h11);
    plan_beat(2'd0, 32'h00);
    run_fill(32'h7000, 0);
    check_eq("dup_slot2", bus_if.fill_data[2*DW +: DW], 32'hBB);

    reset_mid_burst();

    for (int unsigned n = 0; n < 150; n++) begin
      gen_random_plan();
      run_fill($urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
